// File: rtl/safety_island_pkg.sv
// Shared types for the safety island SoC control block:
// register word offsets, FSM states, boot modes and helpers.
package safety_island_pkg;

  localparam logic [9:0] RegBootAddr   = 10'h000;
  localparam logic [9:0] RegFetchEn    = 10'h001;
  localparam logic [9:0] RegCoreStatus = 10'h002;
  localparam logic [9:0] RegBootMode   = 10'h003;

  typedef enum logic [1:0] {
    BootJtag      = 2'b00,
    BootPreloaded = 2'b01
  } bootmode_e;

  typedef enum logic [2:0] {
    StReset  = 3'd0,
    StSample = 3'd1,
    StWait   = 3'd2,
    StRun    = 3'd3,
    StHalt   = 3'd4
  } soc_state_e;

  function automatic logic bootmode_valid(
    input logic [1:0] bm
  );
    return (bm == BootJtag) || (bm == BootPreloaded);
  endfunction

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/safety_island_soc_ctrl_regs.sv
// Register file and bus responder for the SoC control block.
// Decodes word offsets, applies byte enables, registers responses.
module safety_island_soc_ctrl_regs
  import safety_island_pkg::*;
#(
  parameter logic [31:0] BootAddrDefault = 32'h0000_1080,
  parameter int unsigned AddrWidth       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_sample,
  input  logic [1:0]           i_bootmode,
  input  logic                 i_req,
  input  logic [AddrWidth-1:0] i_addr,
  input  logic                 i_we,
  input  logic [3:0]           i_be,
  input  logic [31:0]          i_wdata,
  output logic                 o_rvalid,
  output logic [31:0]          o_rdata,
  output logic                 o_err,
  output logic [31:0]          o_bootaddr,
  output logic                 o_fetchen,
  output logic [31:0]          o_corestatus
);

  logic [31:0] r_bootaddr;
  logic        r_fetchen;
  logic [31:0] r_corestatus;
  logic [1:0]  r_bootmode;
  logic        r_bm_invalid;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [9:0]  w_word;
  logic        w_hit_ba;
  logic        w_hit_fe;
  logic        w_hit_cs;
  logic        w_hit_bm;
  logic        w_err;
  logic        w_wr;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  assign w_word   = i_addr[11:2];
  assign w_hit_ba = (w_word == RegBootAddr);
  assign w_hit_fe = (w_word == RegFetchEn);
  assign w_hit_cs = (w_word == RegCoreStatus);
  assign w_hit_bm = (w_word == RegBootMode);
  assign w_unused_addr =
    ^{i_addr[AddrWidth-1:12], i_addr[1:0]};

  // Classify the access and build read data for the response
  always_comb begin
    w_err   = ~(w_hit_ba | w_hit_fe | w_hit_cs | w_hit_bm)
            | (i_we & w_hit_bm);
    w_wr    = i_req & i_we & ~w_err;
    w_rdata = '0;
    if (!i_we && !w_err) begin
      unique case (1'b1)
        w_hit_ba: w_rdata = r_bootaddr;
        w_hit_fe: w_rdata = {31'b0, r_fetchen};
        w_hit_cs: w_rdata = r_corestatus;
        w_hit_bm: w_rdata = {r_bm_invalid, 29'b0, r_bootmode};
        default:  w_rdata = '0;
      endcase
    end
  end

  // Register writes and the one-shot boot mode capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bootaddr   <= BootAddrDefault;
      r_fetchen    <= 1'b0;
      r_corestatus <= '0;
      r_bootmode   <= '0;
      r_bm_invalid <= 1'b0;
    end else begin
      if (w_wr && w_hit_ba)
        r_bootaddr <= be_merge(r_bootaddr, i_wdata, i_be);
      if (w_wr && w_hit_fe && i_be[0])
        r_fetchen <= i_wdata[0];
      if (w_wr && w_hit_cs)
        r_corestatus <= be_merge(r_corestatus, i_wdata, i_be);
      if (i_sample) begin
        r_bootmode   <= i_bootmode;
        r_bm_invalid <= ~bootmode_valid(i_bootmode);
      end
    end
  end

  // One-cycle registered response to every granted request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= i_req;
      r_rdata  <= i_req ? w_rdata : '0;
      r_err    <= i_req & w_err;
    end
  end

  assign o_rvalid     = r_rvalid;
  assign o_rdata      = r_rdata;
  assign o_err        = r_err;
  assign o_bootaddr   = r_bootaddr;
  assign o_fetchen    = r_fetchen;
  assign o_corestatus = r_corestatus;

endmodule

// File: rtl/safety_island_soc_ctrl.sv
// Safety island SoC control: boot FSM and core-facing outputs.
// Boot address is snapshotted only on the WAIT to RUN transition.
module safety_island_soc_ctrl
  import safety_island_pkg::*;
#(
  parameter logic [31:0] BootAddrDefault = 32'h0000_1080,
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           bootmode_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic                 rvalid_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 err_o,
  output logic [31:0]          boot_addr_o,
  output logic                 fetch_enable_o,
  output logic                 eoc_o,
  output logic [30:0]          exit_code_o
);

  soc_state_e  r_state;
  soc_state_e  w_state_nxt;
  logic [31:0] r_boot_addr;
  logic [31:0] w_bootaddr;
  logic        w_fetchen;
  logic [31:0] w_corestatus;
  logic        w_sample;

  assign gnt_o    = req_i;
  assign w_sample = (r_state == StSample);

  safety_island_soc_ctrl_regs #(
    .BootAddrDefault (BootAddrDefault),
    .AddrWidth       (AddrWidth)
  ) u_regs (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_sample     (w_sample),
    .i_bootmode   (bootmode_i),
    .i_req        (req_i),
    .i_addr       (addr_i),
    .i_we         (we_i),
    .i_be         (be_i),
    .i_wdata      (wdata_i),
    .o_rvalid     (rvalid_o),
    .o_rdata      (rdata_o),
    .o_err        (err_o),
    .o_bootaddr   (w_bootaddr),
    .o_fetchen    (w_fetchen),
    .o_corestatus (w_corestatus)
  );

  // Boot FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= StReset;
    else         r_state <= w_state_nxt;
  end

  // Boot FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StReset:  w_state_nxt = StSample;
      StSample: w_state_nxt = bootmode_valid(bootmode_i)
                            ? StWait : StHalt;
      StWait:   if (w_fetchen) w_state_nxt = StRun;
      StRun:    if (!w_fetchen) w_state_nxt = StWait;
      StHalt:   w_state_nxt = StHalt;
      default:  w_state_nxt = StReset;
    endcase
  end

  // Snapshot the boot address when the core is released
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      r_boot_addr <= BootAddrDefault;
    else if (r_state == StWait && w_state_nxt == StRun)
      r_boot_addr <= w_bootaddr;
  end

  assign boot_addr_o    = r_boot_addr;
  assign fetch_enable_o = (r_state == StRun);
  assign eoc_o          = w_corestatus[31];
  assign exit_code_o    = w_corestatus[30:0];

endmodule

// File: tb/tb_safety_island_soc_ctrl.sv
// Directed bench for safety_island_soc_ctrl.
// Bus tasks issue one request per cycle and check responses.
module tb_safety_island_soc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  bootmode = 2'b01;
  logic        req = 1'b0;
  logic        gnt;
  logic [31:0] addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [31:0] wdata = '0;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] boot_addr;
  logic        fen;
  logic        eoc;
  logic [30:0] exit_code;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  safety_island_soc_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bootmode_i     (bootmode),
    .req_i          (req),
    .gnt_o          (gnt),
    .addr_i         (addr),
    .we_i           (we),
    .be_i           (be),
    .wdata_i        (wdata),
    .rvalid_o       (rvalid),
    .rdata_o        (rdata),
    .err_o          (err),
    .boot_addr_o    (boot_addr),
    .fetch_enable_o (fen),
    .eoc_o          (eoc),
    .exit_code_o    (exit_code)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus(
    input  logic        w,
    input  logic [31:0] a,
    input  logic [3:0]  b,
    input  logic [31:0] d,
    output logic [31:0] rd,
    output logic        e
  );
    @(negedge clk);
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    @(posedge clk);
    #1;
    chk("rvalid", {31'b0, rvalid}, 32'h1);
    rd = rdata;
    e  = err;
    req = 1'b0; we = 1'b0;
  endtask

  task automatic do_reset(input logic [1:0] bm);
    bootmode = bm;
    rst_n = 1'b0;
    req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        e;

  initial begin
    // reset state, observed while reset is asserted
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_boot_addr", boot_addr, 32'h0000_1080);
    chk("rst_fen", {31'b0, fen}, 32'h0);
    chk("rst_eoc", {31'b0, eoc}, 32'h0);
    chk("rst_exit", {1'b0, exit_code}, 32'h0);
    req = 1'b1;
    #1;
    chk("gnt_eq_req", {31'b0, gnt}, 32'h1);
    req = 1'b0;

    do_reset(2'b01);
    bus(1'b0, 32'h0C, 4'hF, 0, rd, e);
    chk("bm_read", rd, 32'h0000_0001);
    chk("bm_read_err", {31'b0, e}, 32'h0);
    bus(1'b0, 32'h00, 4'hF, 0, rd, e);
    chk("ba_default", rd, 32'h0000_1080);
    chk("fen_wait", {31'b0, fen}, 32'h0);

    // rvalid lasts exactly one cycle
    @(posedge clk);
    #1;
    chk("rvalid_one_cycle", {31'b0, rvalid}, 32'h0);

    // release the core
    bus(1'b1, 32'h00, 4'hF, 32'h1C00_0080, rd, e);
    bus(1'b1, 32'h04, 4'hF, 32'h1, rd, e);
    chk("fen_n1", {31'b0, fen}, 32'h0);
    @(posedge clk);
    #1;
    chk("fen_n2", {31'b0, fen}, 32'h1);
    chk("ba_n2", boot_addr, 32'h1C00_0080);

    // BOOTADDR write in RUN is stored but not applied
    bus(1'b1, 32'h00, 4'hF, 32'h2000_0000, rd, e);
    chk("ba_frozen", boot_addr, 32'h1C00_0080);
    bus(1'b0, 32'h00, 4'hF, 0, rd, e);
    chk("ba_stored", rd, 32'h2000_0000);
    bus(1'b1, 32'h04, 4'hF, 32'h0, rd, e);
    chk("fen_off_n1", {31'b0, fen}, 32'h1);
    @(posedge clk);
    #1;
    chk("fen_off_n2", {31'b0, fen}, 32'h0);
    bus(1'b1, 32'h04, 4'hF, 32'h1, rd, e);
    @(posedge clk);
    #1;
    chk("fen_rerun", {31'b0, fen}, 32'h1);
    chk("ba_rerun", boot_addr, 32'h2000_0000);

    // core status
    bus(1'b1, 32'h08, 4'hF, 32'h8000_002A, rd, e);
    chk("eoc_set", {31'b0, eoc}, 32'h1);
    chk("exit_42", {1'b0, exit_code}, 32'd42);
    bus(1'b1, 32'h08, 4'h1, 32'h0000_0005, rd, e);
    chk("exit_5", {1'b0, exit_code}, 32'd5);
    chk("eoc_kept", {31'b0, eoc}, 32'h1);

    // error responses
    bus(1'b0, 32'h10, 4'hF, 0, rd, e);
    chk("err_unmapped", {31'b0, e}, 32'h1);
    chk("err_unmapped_rdata", rd, 32'h0);
    bus(1'b1, 32'h0C, 4'hF, 32'hFFFF_FFFF, rd, e);
    chk("err_ro_write", {31'b0, e}, 32'h1);
    chk("err_ro_rdata", rd, 32'h0);
    bus(1'b0, 32'h0C, 4'hF, 0, rd, e);
    chk("bm_unchanged", rd, 32'h0000_0001);
    bus(1'b1, 32'h10, 4'hF, 32'h0, rd, e);
    chk("err_unmapped_wr", {31'b0, e}, 32'h1);
    chk("fen_after_err", {31'b0, fen}, 32'h1);

    // asynchronous reset with a response pending
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h00; be = 4'hF;
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("pend_rvalid", {31'b0, rvalid}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rvalid", {31'b0, rvalid}, 32'h0);
    chk("async_eoc", {31'b0, eoc}, 32'h0);
    chk("async_ba", boot_addr, 32'h0000_1080);
    chk("async_fen", {31'b0, fen}, 32'h0);

    // invalid boot mode halts the FSM
    do_reset(2'b11);
    bootmode = 2'b00;
    bus(1'b1, 32'h04, 4'hF, 32'h1, rd, e);
    repeat (3) @(posedge clk);
    #1;
    chk("halt_fen", {31'b0, fen}, 32'h0);
    bus(1'b0, 32'h0C, 4'hF, 0, rd, e);
    chk("halt_bm", rd, 32'h8000_0003);
    bus(1'b0, 32'h04, 4'hF, 0, rd, e);
    chk("halt_fe_stored", rd, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
